// File: rtl/dh_pkg.sv
// Shared types and constants for the duck-hunt display/control path.
package dh_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_WAIT_HIT  = 2'd1,
    ST_GAME_OVER = 2'd2
  } score_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] DP_NORMAL = 4'b1011;
  localparam logic [3:0] DP_BLANK  = 4'b1111;

  // Binary 0..99 to packed {tens, ones} BCD; larger values clamp to 99.
  function automatic logic [7:0] to_bcd2(input int unsigned v);
    int unsigned c;
    c = (v > 32'd99) ? 32'd99 : v;
    return {4'(c / 32'd10), 4'(c % 32'd10)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD register: load to INIT, add a BCD step saturating at 99,
// or subtract one with a floor at 00.
module bcd2_counter
  import dh_pkg::*;
#(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_inc,
  input  bcd_t i_step,
  input  logic i_dec,
  output bcd_t o_tens,
  output bcd_t o_ones
);

  bcd_t       r_tens;
  bcd_t       r_ones;
  logic [4:0] w_sum;
  bcd_t       w_inc_tens;
  bcd_t       w_inc_ones;
  bcd_t       w_dec_tens;
  bcd_t       w_dec_ones;

  // Next-value candidates for increment and decrement.
  always_comb begin
    w_sum      = {1'b0, r_ones} + {1'b0, i_step};
    w_inc_tens = r_tens;
    w_inc_ones = r_ones;
    if (w_sum > 5'd9) begin
      if (r_tens == 4'd9) begin
        w_inc_tens = 4'd9;
        w_inc_ones = 4'd9;
      end else begin
        w_inc_tens = r_tens + 4'd1;
        w_inc_ones = 4'(w_sum - 5'd10);
      end
    end else begin
      w_inc_ones = w_sum[3:0];
    end

    w_dec_tens = r_tens;
    w_dec_ones = r_ones;
    if (r_ones != 4'd0) begin
      w_dec_ones = r_ones - 4'd1;
    end else if (r_tens != 4'd0) begin
      w_dec_tens = r_tens - 4'd1;
      w_dec_ones = 4'd9;
    end else begin
      w_dec_ones = 4'd0;
    end
  end

  // Digit registers; load beats increment beats decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tens <= INIT[7:4];
      r_ones <= INIT[3:0];
    end else if (i_load) begin
      r_tens <= INIT[7:4];
      r_ones <= INIT[3:0];
    end else if (i_inc) begin
      r_tens <= w_inc_tens;
      r_ones <= w_inc_ones;
    end else if (i_dec) begin
      r_tens <= w_dec_tens;
      r_ones <= w_dec_ones;
    end else begin
      r_tens <= r_tens;
      r_ones <= r_ones;
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule

// File: rtl/score_ammo_ctl.sv
// Shot/hit/game-over controller: keeps BCD ammo and score, drives the four
// display digits and the decimal-point blink mask.
module score_ammo_ctl
  import dh_pkg::*;
#(
  parameter int AMMO_INIT     = 3,
  parameter int SCORE_PER_HIT = 1,
  parameter int HIT_WINDOW    = 4,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       shot,
  input  logic       hit,
  input  logic       reload,
  input  logic       new_game,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp_out,
  output logic       game_over,
  output logic       shot_accepted
);

  localparam int WIN_W = $clog2(HIT_WINDOW + 1);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(HIT_WINDOW);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [7:0]       AMMO_BCD = to_bcd2(AMMO_INIT);
  localparam bcd_t             HIT_STEP = 4'(SCORE_PER_HIT);

  score_state_t     r_state;
  logic [WIN_W-1:0] r_win;
  logic [BLK_W-1:0] r_blink;
  logic [3:0]       r_dp;
  logic             r_game_over;
  logic             r_shot_acc;

  bcd_t w_ammo_tens;
  bcd_t w_ammo_ones;
  bcd_t w_score_tens;
  bcd_t w_score_ones;
  logic w_ammo_zero;
  logic w_shot_ok;
  logic w_reload_ok;
  logic w_hit_ok;
  logic w_timeout;

  // Event qualification; new_game masks every other input for the cycle.
  always_comb begin
    w_ammo_zero = (w_ammo_tens == 4'd0) && (w_ammo_ones == 4'd0);
    w_shot_ok   = !new_game && (r_state == ST_READY) && shot && !w_ammo_zero;
    w_reload_ok = !new_game && (r_state == ST_READY) && reload && !w_shot_ok;
    w_hit_ok    = !new_game && (r_state == ST_WAIT_HIT) && hit;
    w_timeout   = !new_game && (r_state == ST_WAIT_HIT) && !hit && (r_win == WIN_ONE);
  end

  bcd2_counter #(.INIT(AMMO_BCD)) u_ammo (
    .clk    (clk),
    .rst    (rst),
    .i_load (new_game | w_reload_ok),
    .i_inc  (1'b0),
    .i_step (4'd0),
    .i_dec  (w_shot_ok),
    .o_tens (w_ammo_tens),
    .o_ones (w_ammo_ones)
  );

  bcd2_counter #(.INIT(8'h00)) u_score (
    .clk    (clk),
    .rst    (rst),
    .i_load (new_game),
    .i_inc  (w_hit_ok),
    .i_step (HIT_STEP),
    .i_dec  (1'b0),
    .o_tens (w_score_tens),
    .o_ones (w_score_ones)
  );

  // Game state machine with registered status outputs and dp blink.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      r_state     <= ST_READY;
      r_win       <= '0;
      r_blink     <= '0;
      r_dp        <= DP_NORMAL;
      r_game_over <= 1'b0;
      r_shot_acc  <= 1'b0;
    end else begin
      r_shot_acc <= 1'b0;
      case (r_state)
        ST_READY: begin
          if (w_shot_ok) begin
            r_shot_acc <= 1'b1;
            r_win      <= WIN_LOAD;
            r_state    <= ST_WAIT_HIT;
          end
        end
        ST_WAIT_HIT: begin
          if (w_hit_ok) begin
            r_state <= ST_READY;
          end else if (w_timeout) begin
            r_win <= '0;
            if (w_ammo_zero) begin
              r_state     <= ST_GAME_OVER;
              r_game_over <= 1'b1;
              r_blink     <= '0;
              r_dp        <= DP_NORMAL;
            end else begin
              r_state <= ST_READY;
            end
          end else begin
            r_win <= r_win - WIN_ONE;
          end
        end
        ST_GAME_OVER: begin
          if (new_frame) begin
            if (r_blink == BLK_LAST) begin
              r_blink <= '0;
              r_dp    <= (r_dp == DP_NORMAL) ? DP_BLANK : DP_NORMAL;
            end else begin
              r_blink <= r_blink + BLK_W'(1);
            end
          end
        end
        default: begin
          r_state     <= ST_READY;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign hex0          = w_ammo_ones;
  assign hex1          = w_ammo_tens;
  assign hex2          = w_score_ones;
  assign hex3          = w_score_tens;
  assign dp_out        = r_dp;
  assign game_over     = r_game_over;
  assign shot_accepted = r_shot_acc;

endmodule

// File: doc/score_ammo_ctl.md
Name: score_ammo_ctl

Overview:
- Game-state producer for the seven-segment display path.
- Counts shots and hits, keeps ammo and score as 2-digit BCD, and runs the shot/hit/game-over state machine.
- Drives the four BCD digits and the decimal-point mask that disp_hex_mux consumes.
- Sits in the ctrl section beside ctl_duck, on the 65 MHz clk domain.

Parameters:
- AMMO_INIT, 3: ammo loaded at reset, new_game and reload; BCD-representable, 0..99.
- SCORE_PER_HIT, 1: points added per confirmed hit, 1..9.
- HIT_WINDOW, 4: clk cycles after an accepted shot during which a hit pulse is credited, ≥1.
- BLINK_FRAMES, 32: new_frame pulses per half-period of the game-over dp blink.

Ports:
- clk  in  1  main 65 MHz clock
- rst  in  1  synchronous active-high reset
- new_frame  in  1  one-cycle pulse per VGA frame
- shot  in  1  one-cycle trigger pulse
- hit  in  1  one-cycle pulse, shot landed on the duck
- reload  in  1  one-cycle pulse, refill ammo for the next duck
- new_game  in  1  one-cycle pulse, restart the game
- hex0  out  4  ammo ones digit (BCD)
- hex1  out  4  ammo tens digit (BCD)
- hex2  out  4  score ones digit (BCD)
- hex3  out  4  score tens digit (BCD)
- dp_out  out  4  decimal-point mask, passed unchanged to the display mux
- game_over  out  1  high while in ST_GAME_OVER
- shot_accepted  out  1  one-cycle pulse, shot consumed ammo

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: score=00, ammo=AMMO_INIT, state=ST_READY, hex3..hex0 = score and ammo digits, dp_out=4'b1011, game_over=0, shot_accepted=0, blink counter=0.
- All outputs are registered. Digits reflect counter updates 1 cycle after the causing input edge.
- ST_READY:
  - shot with ammo>0: ammo decrements by BCD (tens borrow, e.g. 10→09), shot_accepted=1 for that cycle, window counter loads HIT_WINDOW, go to ST_WAIT_HIT.
  - shot with ammo=00: ignored, no pulse.
  - hit: ignored, since no shot is pending.
  - reload: ammo=AMMO_INIT.
- ST_WAIT_HIT:
  - Window counter decrements every cycle.
  - hit while counter>0: score += SCORE_PER_HIT, BCD with carry, saturating at 99. Go to ST_READY.
  - Counter reaches 0 without a hit: miss. If ammo=00, go to ST_GAME_OVER; otherwise go to ST_READY.
  - shot and reload are ignored here.
  - hit and timeout in the same cycle: the hit wins.
  - A hit on the last ammo still returns to ST_READY. Game over occurs only on a miss with ammo=00.
- ST_GAME_OVER:
  - game_over=1; score and ammo hold.
  - Blink counter counts new_frame pulses. dp_out toggles between 4'b1011 and 4'b1111 every BLINK_FRAMES frames.
  - shot, hit and reload are ignored.
- new_game, in any state: score=00, ammo=AMMO_INIT, state=ST_READY, blink counter=0, dp_out=4'b1011. new_game has priority over all other inputs in the same cycle. rst has priority over new_game.
- rst mid-ST_WAIT_HIT: the pending shot is discarded and the reset values apply next cycle.
- BCD invariant: every digit stays ≤9 at all times. Ammo decrement at 00 never occurs.

Decomposition:
- Shared package dh_pkg holds:
  - typedef enum logic [1:0] {ST_READY, ST_WAIT_HIT, ST_GAME_OVER} score_state_t
  - typedef logic [3:0] bcd_t
  - constant DP_NORMAL=4'b1011
  - constant DP_BLANK=4'b1111
- Sub-module bcd2_counter: 2-digit BCD register with inc(step), dec-by-1, load, saturate at 99 and floor at 00. Instantiated twice, once for score and once for ammo.

Test Plan:
- Reset with AMMO_INIT=3: rst for 2 cycles → hex3..0 = 0,0,0,3, dp_out=1011, game_over=0.
- Hit inside window: shot then hit 2 cycles later → shot_accepted pulse; next cycle ammo=02, score=01; state back to ST_READY.
- Misses to game over: 3 shots, no hits, each waits HIT_WINDOW → ammo 02→01→00. After the third window game_over=1. Further shot → no shot_accepted, digits unchanged.
- BCD edges:
  - AMMO_INIT=10, one shot → hex1,hex0 = 0,9.
  - Score preloaded to 99 via 99 hits, one more hit → score stays 9,9.
  - Score 09 + hit → 1,0.
- Ignored inputs: hit in ST_READY → no change. Second shot during ST_WAIT_HIT → ammo decremented once only. hit and timeout same cycle → score +1.
- Blink and restart: in ST_GAME_OVER, 32 new_frame pulses → dp_out=1111, 32 more → 1011. new_game → score 00, ammo 03, game_over=0 next cycle. rst asserted during ST_WAIT_HIT → reset values, pending hit not credited.
